// File: rtl/hazard_pkg.sv
// Shared types for the RV32 hazard/scoreboard unit: register address type and
// forwarding mux select encoding.
package hazard_pkg;
  localparam int REGISTER_ADDRESS_WIDTH = 5;

  typedef logic [REGISTER_ADDRESS_WIDTH-1:0] reg_addr_t;

  typedef enum logic [1:0] {
    FWD_RF = 2'b00,
    FWD_W  = 2'b01,
    FWD_M  = 2'b10
  } forward_sel_e;
endpackage

// File: rtl/mdu_rd_fifo.sv
// In-order FIFO of destination registers for outstanding MDU ops.
// Head is the rd of the oldest op, or 0 when empty.
module mdu_rd_fifo #(
  parameter int DEPTH = 2,
  parameter int WIDTH = 5
) (
  input  logic                       clk_i,
  input  logic                       rst_i,
  input  logic                       push_i,
  input  logic                       pop_i,
  input  logic [WIDTH-1:0]           din_i,
  output logic [WIDTH-1:0]           head_o,
  output logic [$clog2(DEPTH+1)-1:0] count_o
);
  localparam int PW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int CW = $clog2(DEPTH+1);

  logic [WIDTH-1:0] mem_q [DEPTH];
  logic [WIDTH-1:0] mem_d [DEPTH];
  logic [PW-1:0]    wr_q, wr_d, rd_q, rd_d;
  logic [CW-1:0]    cnt_q, cnt_d;
  logic             do_push, do_pop;

  function automatic logic [PW-1:0] ptr_inc(input logic [PW-1:0] p);
    return (p == PW'(DEPTH-1)) ? '0 : p + 1'b1;
  endfunction

  // A pop on an empty FIFO is dropped; a push is only taken if there is room.
  assign do_pop  = pop_i && (cnt_q != '0);
  assign do_push = push_i && ((cnt_q != CW'(DEPTH)) || do_pop);

  always_comb begin
    mem_d = mem_q;
    wr_d  = wr_q;
    rd_d  = rd_q;
    cnt_d = cnt_q;
    if (do_push) begin
      mem_d[wr_q] = din_i;
      wr_d        = ptr_inc(wr_q);
    end
    if (do_pop) rd_d = ptr_inc(rd_q);
    if (do_push && !do_pop)      cnt_d = cnt_q + 1'b1;
    else if (!do_push && do_pop) cnt_d = cnt_q - 1'b1;
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      mem_q <= '{default: '0};
      wr_q  <= '0;
      rd_q  <= '0;
      cnt_q <= '0;
    end else begin
      mem_q <= mem_d;
      wr_q  <= wr_d;
      rd_q  <= rd_d;
      cnt_q <= cnt_d;
    end
  end

  assign head_o  = (cnt_q == '0) ? '0 : mem_q[rd_q];
  assign count_o = cnt_q;
endmodule

// File: rtl/hazard_scoreboard_unit.sv
// Hazard unit for the 5-stage RV32 pipe with an MDU register scoreboard.
// Optional perf counters are built when HAZARD_PERF_EN is defined.
module hazard_scoreboard_unit #(
  parameter int REGISTER_ADDRESS_WIDTH = hazard_pkg::REGISTER_ADDRESS_WIDTH,
  parameter int NUM_REGS               = 2**REGISTER_ADDRESS_WIDTH,
  parameter int MDU_DEPTH              = 2,
  parameter int PERF_WIDTH             = 32
) (
  input  logic                              clk_i,
  input  logic                              rst_i,
  input  logic [REGISTER_ADDRESS_WIDTH-1:0] Rs1D_i,
  input  logic [REGISTER_ADDRESS_WIDTH-1:0] Rs2D_i,
  input  logic [REGISTER_ADDRESS_WIDTH-1:0] RdD_i,
  input  logic                              RegWriteD_i,
  input  logic                              MduStartD_i,
  input  logic [REGISTER_ADDRESS_WIDTH-1:0] Rs1E_i,
  input  logic [REGISTER_ADDRESS_WIDTH-1:0] Rs2E_i,
  input  logic [REGISTER_ADDRESS_WIDTH-1:0] RdE_i,
  input  logic                              ResultSrcE0_i,
  input  logic                              MduStartE_i,
  input  logic [REGISTER_ADDRESS_WIDTH-1:0] RdM_i,
  input  logic                              RegWriteM_i,
  input  logic [REGISTER_ADDRESS_WIDTH-1:0] RdW_i,
  input  logic                              RegWriteW_i,
  input  logic                              MduDone_i,
  input  logic                              PCSrcE_i,
  input  logic                              CacheStall_i,
  output logic [1:0]                        ForwardAE_o,
  output logic [1:0]                        ForwardBE_o,
  output logic                              StallF_o,
  output logic                              StallD_o,
  output logic                              StallE_o,
  output logic                              StallM_o,
  output logic                              StallW_o,
  output logic                              FlushD_o,
  output logic                              FlushE_o,
  output logic [REGISTER_ADDRESS_WIDTH-1:0] MduRdDone_o,
  output logic                              MduBusy_o,
  output logic [PERF_WIDTH-1:0]             PerfLoadStall_o,
  output logic [PERF_WIDTH-1:0]             PerfSbStall_o,
  output logic [PERF_WIDTH-1:0]             PerfFlush_o
);
  import hazard_pkg::*;

  localparam int AW = REGISTER_ADDRESS_WIDTH;
  localparam int CW = $clog2(MDU_DEPTH+1);

  logic [NUM_REGS-1:0] pending_q, pending_d;
  logic [CW-1:0]       count;
  logic [AW-1:0]       head;
  logic                issue, done, busy;
  logic                lw_stall, sb_stall, mdu_full, hazard;
  forward_sel_e        fwd_a, fwd_b;

  mdu_rd_fifo #(.DEPTH(MDU_DEPTH), .WIDTH(AW)) u_rd_fifo (
    .clk_i   (clk_i),
    .rst_i   (rst_i),
    .push_i  (issue),
    .pop_i   (done),
    .din_i   (RdE_i),
    .head_o  (head),
    .count_o (count)
  );

  assign busy  = (count != '0);
  assign issue = MduStartE_i && !CacheStall_i;
  assign done  = MduDone_i && busy;

  // MDU ops travel with RegWrite=0, so they never match here.
  always_comb begin
    fwd_a = FWD_RF;
    fwd_b = FWD_RF;
    if (RegWriteM_i && RdM_i != '0 && RdM_i == Rs1E_i)      fwd_a = FWD_M;
    else if (RegWriteW_i && RdW_i != '0 && RdW_i == Rs1E_i) fwd_a = FWD_W;
    if (RegWriteM_i && RdM_i != '0 && RdM_i == Rs2E_i)      fwd_b = FWD_M;
    else if (RegWriteW_i && RdW_i != '0 && RdW_i == Rs2E_i) fwd_b = FWD_W;
  end

  assign lw_stall = ResultSrcE0_i && RdE_i != '0 && (Rs1D_i == RdE_i || Rs2D_i == RdE_i);
  assign sb_stall = (Rs1D_i != '0 && pending_q[Rs1D_i]) ||
                    (Rs2D_i != '0 && pending_q[Rs2D_i]) ||
                    (RegWriteD_i && RdD_i != '0 && pending_q[RdD_i]);
  assign mdu_full = MduStartD_i && ((int'(count) + int'(MduStartE_i)) >= MDU_DEPTH);
  assign hazard   = lw_stall | sb_stall | mdu_full;

  // Clear before set so an issue to the retiring rd keeps the bit pending.
  always_comb begin
    pending_d = pending_q;
    if (done) pending_d[head] = 1'b0;
    if (issue && RdE_i != '0) pending_d[RdE_i] = 1'b1;
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) pending_q <= '0;
    else       pending_q <= pending_d;
  end

  assign ForwardAE_o = fwd_a;
  assign ForwardBE_o = fwd_b;
  assign StallF_o    = hazard | CacheStall_i;
  assign StallD_o    = hazard | CacheStall_i;
  assign StallE_o    = CacheStall_i;
  assign StallM_o    = CacheStall_i;
  assign StallW_o    = CacheStall_i;
  assign FlushD_o    = !CacheStall_i && PCSrcE_i;
  assign FlushE_o    = !CacheStall_i && (hazard | PCSrcE_i);
  assign MduRdDone_o = head;
  assign MduBusy_o   = busy;

`ifdef HAZARD_PERF_EN
  logic [PERF_WIDTH-1:0] perf_ld_q, perf_ld_d, perf_sb_q, perf_sb_d, perf_fl_q, perf_fl_d;

  function automatic logic [PERF_WIDTH-1:0] sat_inc(input logic [PERF_WIDTH-1:0] v,
                                                    input logic en);
    return (en && v != '1) ? v + 1'b1 : v;
  endfunction

  always_comb begin
    perf_ld_d = sat_inc(perf_ld_q, lw_stall && !CacheStall_i);
    perf_sb_d = sat_inc(perf_sb_q, (sb_stall | mdu_full) && !CacheStall_i);
    perf_fl_d = sat_inc(perf_fl_q, FlushD_o);
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      perf_ld_q <= '0;
      perf_sb_q <= '0;
      perf_fl_q <= '0;
    end else begin
      perf_ld_q <= perf_ld_d;
      perf_sb_q <= perf_sb_d;
      perf_fl_q <= perf_fl_d;
    end
  end

  assign PerfLoadStall_o = perf_ld_q;
  assign PerfSbStall_o   = perf_sb_q;
  assign PerfFlush_o     = perf_fl_q;
`else
  assign PerfLoadStall_o = '0;
  assign PerfSbStall_o   = '0;
  assign PerfFlush_o     = '0;
`endif
endmodule

// File: tb/tb_hazard_scoreboard_unit.sv
// Self-checking bench: vector table, hand-written MDU sequences, and a random
// run against a queue-based model of the scoreboard.
module tb_hazard_scoreboard_unit;
  localparam int AW    = 5;
  localparam int DEPTH = 2;
  localparam int PW    = 32;

  logic clk = 1'b0;
  logic rst_i;
  logic [AW-1:0] Rs1D, Rs2D, RdD, Rs1E, Rs2E, RdE, RdM, RdW;
  logic RegWriteD, MduStartD, ResultSrcE0, MduStartE, RegWriteM, RegWriteW;
  logic MduDone, PCSrcE, CacheStall;
  logic [1:0] FwdA, FwdB;
  logic StallF, StallD, StallE, StallM, StallW, FlushD, FlushE, MduBusy;
  logic [AW-1:0] MduRdDone;
  logic [PW-1:0] PerfLd, PerfSb, PerfFl;

  int n_chk = 0;
  int n_fail = 0;

  always #5 clk = ~clk;

  hazard_scoreboard_unit #(.REGISTER_ADDRESS_WIDTH(AW), .NUM_REGS(32),
                           .MDU_DEPTH(DEPTH), .PERF_WIDTH(PW)) dut (
    .clk_i(clk), .rst_i(rst_i),
    .Rs1D_i(Rs1D), .Rs2D_i(Rs2D), .RdD_i(RdD), .RegWriteD_i(RegWriteD),
    .MduStartD_i(MduStartD), .Rs1E_i(Rs1E), .Rs2E_i(Rs2E), .RdE_i(RdE),
    .ResultSrcE0_i(ResultSrcE0), .MduStartE_i(MduStartE),
    .RdM_i(RdM), .RegWriteM_i(RegWriteM), .RdW_i(RdW), .RegWriteW_i(RegWriteW),
    .MduDone_i(MduDone), .PCSrcE_i(PCSrcE), .CacheStall_i(CacheStall),
    .ForwardAE_o(FwdA), .ForwardBE_o(FwdB),
    .StallF_o(StallF), .StallD_o(StallD), .StallE_o(StallE), .StallM_o(StallM),
    .StallW_o(StallW), .FlushD_o(FlushD), .FlushE_o(FlushE),
    .MduRdDone_o(MduRdDone), .MduBusy_o(MduBusy),
    .PerfLoadStall_o(PerfLd), .PerfSbStall_o(PerfSb), .PerfFlush_o(PerfFl)
  );

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // The stimulus must never pulse done on an empty MDU.
  always @(posedge clk) begin
    if (!rst_i && MduDone) begin
      n_chk++;
      if (!MduBusy) begin
        n_fail++;
        $display("FAIL done_on_empty: got busy=0 expected busy=1 at %0t", $time);
      end
    end
  end

  task automatic idle();
    {Rs1D, Rs2D, RdD, Rs1E, Rs2E, RdE, RdM, RdW} = '0;
    {RegWriteD, MduStartD, ResultSrcE0, MduStartE, RegWriteM, RegWriteW} = '0;
    {MduDone, PCSrcE, CacheStall} = '0;
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic settle();
    @(negedge clk);
  endtask

  task automatic do_reset();
    idle();
    rst_i = 1'b1;
    step();
    step();
    rst_i = 1'b0;
  endtask

  typedef struct {
    logic [AW-1:0] rs1d, rs2d, rdd;
    logic          rwd, msd;
    logic [AW-1:0] rs1e, rs2e, rde;
    logic          ld;
    logic [AW-1:0] rdm;
    logic          rwm;
    logic [AW-1:0] rdw;
    logic          rww, pcsrc, cache;
    logic [1:0]    fa, fb;
    logic          sfd, semw, fd, fe;
  } vec_t;

  vec_t vt[8];

  // Random-phase model state
  logic [31:0] pend;
  int          q[$];
  int          m_ld, m_sb, m_fl;

  initial begin
    rst_i = 1'b0;
    vt[0] = '{5,1,6,1,0, 0,0,5,1, 0,0, 0,0, 0,0, 2'b00,2'b00, 1,0,0,1};
    vt[1] = '{0,1,6,1,0, 0,0,0,1, 0,0, 0,0, 0,0, 2'b00,2'b00, 0,0,0,0};
    vt[2] = '{0,0,0,0,0, 3,0,0,0, 3,1, 3,1, 0,0, 2'b10,2'b00, 0,0,0,0};
    vt[3] = '{0,0,0,0,0, 0,0,0,0, 3,1, 3,1, 0,0, 2'b00,2'b00, 0,0,0,0};
    vt[4] = '{0,0,0,0,0, 3,4,0,0, 3,0, 3,1, 0,0, 2'b01,2'b00, 0,0,0,0};
    vt[5] = '{0,0,0,0,0, 0,4,0,0, 4,1, 4,1, 1,0, 2'b00,2'b10, 0,0,1,1};
    vt[6] = '{5,0,0,0,0, 0,0,5,1, 0,0, 0,0, 1,1, 2'b00,2'b00, 1,1,0,0};
    vt[7] = '{0,9,0,0,1, 7,0,9,0, 7,1, 0,0, 0,0, 2'b10,2'b00, 0,0,0,0};

    do_reset();
    settle();
    chk("rst_busy", MduBusy, 0);
    chk("rst_rddone", MduRdDone, 0);
    chk("rst_stallD", StallD, 0);
    chk("rst_perf", PerfLd | PerfSb | PerfFl, 0);

    for (int i = 0; i < 8; i++) begin
      step();
      idle();
      Rs1D = vt[i].rs1d; Rs2D = vt[i].rs2d; RdD = vt[i].rdd;
      RegWriteD = vt[i].rwd; MduStartD = vt[i].msd;
      Rs1E = vt[i].rs1e; Rs2E = vt[i].rs2e; RdE = vt[i].rde; ResultSrcE0 = vt[i].ld;
      RdM = vt[i].rdm; RegWriteM = vt[i].rwm; RdW = vt[i].rdw; RegWriteW = vt[i].rww;
      PCSrcE = vt[i].pcsrc; CacheStall = vt[i].cache;
      settle();
      chk($sformatf("vec%0d_fwdA", i), FwdA, vt[i].fa);
      chk($sformatf("vec%0d_fwdB", i), FwdB, vt[i].fb);
      chk($sformatf("vec%0d_stallFD", i), {StallF, StallD}, {vt[i].sfd, vt[i].sfd});
      chk($sformatf("vec%0d_stallEMW", i), {StallE, StallM, StallW}, {3{vt[i].semw}});
      chk($sformatf("vec%0d_flushD", i), FlushD, vt[i].fd);
      chk($sformatf("vec%0d_flushE", i), FlushE, vt[i].fe);
    end

    // mul x7 then a reader of x7 in D
    do_reset();
    MduStartE = 1; RdE = 7;
    settle();
    chk("mul7_busy_before", MduBusy, 0);
    step();
    idle(); Rs1D = 7; RegWriteD = 1; RdD = 10;
    settle();
    chk("mul7_raw_stall", StallD, 1);
    chk("mul7_raw_flushE", FlushE, 1);
    chk("mul7_head", MduRdDone, 7);
    step();
    settle();
    chk("mul7_stall_hold", StallF, 1);
    step();
    MduDone = 1;
    settle();
    chk("mul7_done_head", MduRdDone, 7);
    chk("mul7_stall_on_done", StallD, 1);
    step();
    MduDone = 0;
    settle();
    chk("mul7_release", StallD, 0);
    chk("mul7_idle", MduBusy, 0);

    // back-to-back issue, structural stall, in-order retire
    step();
    idle(); MduStartE = 1; RdE = 8; MduStartD = 1;
    settle();
    chk("full_first", StallD, 0);
    step();
    RdE = 9;
    settle();
    chk("full_second", StallD, 1);
    step();
    MduStartE = 0;
    settle();
    chk("full_held", StallD, 1);
    chk("fifo_head8", MduRdDone, 8);
    step();
    MduStartD = 0; MduDone = 1;
    settle();
    chk("pop_head8", MduRdDone, 8);
    step();
    settle();
    chk("pop_head9", MduRdDone, 9);
    chk("pop_busy", MduBusy, 1);
    step();
    MduDone = 0;
    settle();
    chk("pop_empty", MduBusy, 0);
    chk("pop_head0", MduRdDone, 0);

    // cache freeze: pop taken, push refused
    step();
    idle(); MduStartE = 1; RdE = 10;
    step();
    CacheStall = 1; RdE = 11; MduDone = 1;
    settle();
    chk("cache_stallEMW", {StallE, StallM, StallW}, 3'b111);
    chk("cache_flush", {FlushD, FlushE}, 2'b00);
    chk("cache_head", MduRdDone, 10);
    step();
    idle(); Rs1D = 11;
    settle();
    chk("cache_nopush", MduBusy, 0);
    chk("cache_no_sb", StallD, 0);
    step();
    idle(); PCSrcE = 1;
    settle();
    chk("branch_flush", {FlushD, FlushE}, 2'b11);

    // reset with ops pending, then perf count
    step();
    idle(); MduStartE = 1; RdE = 12;
    step();
    RdE = 13;
    step();
    idle(); rst_i = 1;
    step();
    rst_i = 0; Rs1D = 12; Rs2D = 13;
    settle();
    chk("rst_mid_busy", MduBusy, 0);
    chk("rst_mid_sb", StallD, 0);
    chk("rst_mid_perf", PerfLd, 0);
    for (int k = 0; k < 3; k++) begin
      step();
      idle(); ResultSrcE0 = 1; RdE = 5; Rs2D = 5;
    end
    step();
    idle();
    settle();
`ifdef HAZARD_PERF_EN
    chk("perf_load3", PerfLd, 3);
`else
    chk("perf_tied0", PerfLd | PerfSb | PerfFl, 0);
`endif

    // random run against the model
    do_reset();
    pend = '0; q.delete(); m_ld = 0; m_sb = 0; m_fl = 0;
    for (int c = 0; c < 3000; c++) begin
      logic lw, sb, full, hz;
      logic [1:0] efa, efb;
      idle();
      Rs1D = AW'($urandom_range(0, 7)); Rs2D = AW'($urandom_range(0, 7));
      RdD = AW'($urandom_range(0, 7)); RegWriteD = 1'($urandom);
      MduStartD = 1'($urandom);
      Rs1E = AW'($urandom_range(0, 7)); Rs2E = AW'($urandom_range(0, 7));
      RdE = AW'($urandom_range(0, 7)); ResultSrcE0 = ($urandom_range(0, 3) == 0);
      RdM = AW'($urandom_range(0, 7)); RegWriteM = 1'($urandom);
      RdW = AW'($urandom_range(0, 7)); RegWriteW = 1'($urandom);
      PCSrcE = ($urandom_range(0, 5) == 0); CacheStall = ($urandom_range(0, 7) == 0);
      MduStartE = (q.size() < DEPTH) && ($urandom_range(0, 2) == 0);
      MduDone = (q.size() > 0) && ($urandom_range(0, 2) == 0);

      lw   = ResultSrcE0 && RdE != 0 && (Rs1D == RdE || Rs2D == RdE);
      sb   = (Rs1D != 0 && pend[Rs1D]) || (Rs2D != 0 && pend[Rs2D]) ||
             (RegWriteD && RdD != 0 && pend[RdD]);
      full = MduStartD && (q.size() + int'(MduStartE) >= DEPTH);
      hz   = lw | sb | full;
      efa  = (RegWriteM && RdM != 0 && RdM == Rs1E) ? 2'b10 :
             (RegWriteW && RdW != 0 && RdW == Rs1E) ? 2'b01 : 2'b00;
      efb  = (RegWriteM && RdM != 0 && RdM == Rs2E) ? 2'b10 :
             (RegWriteW && RdW != 0 && RdW == Rs2E) ? 2'b01 : 2'b00;
      settle();
      chk("rnd_fwdA", FwdA, efa);
      chk("rnd_fwdB", FwdB, efb);
      chk("rnd_stallFD", {StallF, StallD}, {2{hz | CacheStall}});
      chk("rnd_stallEMW", {StallE, StallM, StallW}, {3{CacheStall}});
      chk("rnd_flushD", FlushD, !CacheStall && PCSrcE);
      chk("rnd_flushE", FlushE, !CacheStall && (hz | PCSrcE));
      chk("rnd_head", MduRdDone, (q.size() > 0) ? 32'(q[0]) : 0);
      chk("rnd_busy", MduBusy, q.size() > 0);
`ifdef HAZARD_PERF_EN
      chk("rnd_perf", {PerfLd[9:0], PerfSb[9:0], PerfFl[9:0]},
          {10'(m_ld), 10'(m_sb), 10'(m_fl)});
`else
      chk("rnd_perf", PerfLd | PerfSb | PerfFl, 0);
`endif
      @(posedge clk);
      if (MduDone && q.size() > 0) pend[q.pop_front()] = 1'b0;
      if (MduStartE && !CacheStall) begin
        q.push_back(int'(RdE));
        if (RdE != 0) pend[RdE] = 1'b1;
      end
      if (lw && !CacheStall) m_ld++;
      if ((sb | full) && !CacheStall) m_sb++;
      if (!CacheStall && PCSrcE) m_fl++;
      #1;
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule
